// File: rtl/dst_track.sv
// dst_track: destination/Tnew tracker with decode stall and optional forwarding selects (DST_FWD_EN)
module dst_track #(
  parameter int ADDR_W = 5,
  parameter int DEPTH = 3,
  parameter int TNEW_W = 2,
  parameter int FSEL_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall_in,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        d_rt,
  input  logic [ADDR_W-1:0]        d_rd,
  input  logic [1:0]               d_dstsel,
  input  logic                     d_we,
  input  logic [TNEW_W-1:0]        d_tnew,
  input  logic [ADDR_W-1:0]        d_rs_q,
  input  logic [ADDR_W-1:0]        d_rt_q,
  input  logic [TNEW_W-1:0]        d_tuse_rs,
  input  logic [TNEW_W-1:0]        d_tuse_rt,
  output logic [DEPTH*ADDR_W-1:0]  stg_dst,
  output logic [DEPTH*TNEW_W-1:0]  stg_tnew,
  output logic                     stall_req,
  output logic [FSEL_W-1:0]        fwd_rs,
  output logic [FSEL_W-1:0]        fwd_rt
);
  logic [ADDR_W-1:0] dst [DEPTH];
  logic [TNEW_W-1:0] tn [DEPTH];
  logic [ADDR_W-1:0] sel;
  logic bubble, mrs, mrt;
  assign sel = !d_we ? '0 : d_dstsel == 2'b00 ? d_rt : d_dstsel == 2'b01 ? d_rd :
               d_dstsel == 2'b10 ? ADDR_W'(31) : '0;
  assign bubble = stall_in | stall_req | flush;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        dst[i] <= '0;
        tn[i] <= '0;
      end
    end else begin
      dst[0] <= bubble ? '0 : sel;
      tn[0] <= bubble ? '0 : d_tnew;
      for (int i = 1; i < DEPTH; i++) begin
        dst[i] <= dst[i-1];
        tn[i] <= |tn[i-1] ? tn[i-1] - 1'b1 : '0;
      end
    end
  end
  for (genvar k = 0; k < DEPTH; k++) begin : g_pack
    assign stg_dst[k*ADDR_W +: ADDR_W] = dst[k];
    assign stg_tnew[k*TNEW_W +: TNEW_W] = tn[k];
  end
  // Descending scan so the nearest qualifying stage overwrites farther ones
  always_comb begin
    stall_req = 1'b0;
    fwd_rs = '0;
    fwd_rt = '0;
    mrs = 1'b0;
    mrt = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      mrs = |d_rs_q && dst[k] == d_rs_q;
      mrt = |d_rt_q && dst[k] == d_rt_q;
`ifdef DST_FWD_EN
      if ((mrs && tn[k] > d_tuse_rs) || (mrt && tn[k] > d_tuse_rt)) stall_req = 1'b1;
      if (mrs && !(|tn[k])) fwd_rs = FSEL_W'(k + 1);
      if (mrt && !(|tn[k])) fwd_rt = FSEL_W'(k + 1);
`else
      if (k < DEPTH - 1 && (mrs || mrt)) stall_req = 1'b1;
`endif
    end
  end
`ifndef DST_FWD_EN
  logic unused;
  assign unused = ^{d_tuse_rs, d_tuse_rt};
`endif
endmodule
